// File: rtl/common.sv
// Shared fetch definitions: reset PC and the fetch FSM state encoding.
package common;
  localparam logic [63:0] PCINIT = 64'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/fetch_pc.sv
// Program counter register with load enable and async active-low reset to PC_INIT.
module fetch_pc #(
  parameter logic [63:0] PC_INIT = common::PCINIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_en,
  input  logic [63:0] pc_d,
  output logic [63:0] pc_q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pc_q <= PC_INIT;
    else if (ld_en) pc_q <= pc_d;
  end
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: sequences bus requests, holds the fetched
// instruction for decode and applies execute redirects without cancelling bus traffic.
module fetch_ctrl
  import common::*;
#(
  parameter logic [63:0] PC_INIT = PCINIT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] fetch_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc
);
  fetch_state_t state_q, state_d;
  logic [63:0]  pending_q, pending_d;
  logic         inst_valid_q, inst_valid_d;
  logic [31:0]  inst_q, inst_d;
  logic [63:0]  inst_pc_q, inst_pc_d;
  logic         pc_ld;
  logic [63:0]  pc_nxt;
  logic [63:0]  pc_q;

  fetch_pc #(.PC_INIT(PC_INIT)) u_pc (
    .clk   (clk),
    .rst_n (reset),
    .ld_en (pc_ld),
    .pc_d  (pc_nxt),
    .pc_q  (pc_q)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    pc_ld        = 1'b0;
    pc_nxt       = pc_q + 64'd4;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) begin
          pc_ld  = 1'b1;
          pc_nxt = redirect_pc;
        end
      end
      REQ: begin
        if (iresp_ok && !redirect_valid) begin
          inst_d       = iresp_data;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          state_d      = HOLD;
        end else if (iresp_ok) begin
          pc_ld   = 1'b1;
          pc_nxt  = redirect_pc;
          state_d = IDLE;
        end else if (redirect_valid) begin
          pending_d = redirect_pc;
          state_d   = FLUSH;
        end
      end
      // The bus cannot cancel, so the old request rides out and its data is dropped.
      FLUSH: begin
        if (iresp_ok) begin
          pc_ld   = 1'b1;
          pc_nxt  = redirect_valid ? redirect_pc : pending_q;
          state_d = IDLE;
        end else if (redirect_valid) begin
          pending_d = redirect_pc;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_ld        = 1'b1;
          pc_nxt       = redirect_pc;
          inst_valid_d = 1'b0;
          state_d      = IDLE;
        end else if (!stall) begin
          pc_ld        = 1'b1;
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign ireq_valid = (state_q == REQ) || (state_q == FLUSH);
  assign ireq_addr  = pc_q;
  assign fetch_pc   = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
endmodule
